// File: rtl/nmr_fault_monitor.sv
// N-modular-redundancy voter with per-lane blame tracking and lane quarantine.
// Majority is taken over the active (non-quarantined) lanes; results are registered.
module nmr_fault_monitor #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned LANES       = 3,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned FAIL_THRESH = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   valid_i,
   input  logic [LANES*WIDTH-1:0] lane_data_i,
   input  logic                   clear_i,
   output logic [WIDTH-1:0]       voted_o,
   output logic                   voted_valid_o,
   output logic [LANES-1:0]       lane_fault_o,
   output logic [LANES-1:0]       lane_failed_o,
   output logic [LANES*CNT_W-1:0] fault_count_o,
   output logic                   system_fault_o,
   output logic [CNT_W-1:0]       sys_fault_count_o,
   output logic                   degraded_o
);

   localparam int unsigned AW = $clog2(LANES + 1);
   localparam logic [AW-1:0] ONE = AW'(1);
   localparam logic [7:0] THRESH = 8'(FAIL_THRESH);

   logic [WIDTH-1:0] lane [LANES];
   logic [LANES-1:0] active;
   logic [AW-1:0]    n_active;
   logic [AW-1:0]    agree [LANES];
   logic             has_maj;
   logic [WIDTH-1:0] maj_val;
   logic [LANES-1:0] blame;

   logic [LANES-1:0] failed_q, failed_d;
   logic [7:0]       streak_q [LANES];
   logic [7:0]       streak_d [LANES];
   logic [CNT_W-1:0] fault_cnt_q [LANES];
   logic [CNT_W-1:0] fault_cnt_d [LANES];
   logic [CNT_W-1:0] sys_cnt_q, sys_cnt_d;
   logic [WIDTH-1:0] voted_q, voted_d;
   logic             voted_valid_q, voted_valid_d;
   logic [LANES-1:0] lane_fault_q, lane_fault_d;
   logic             sys_fault_q, sys_fault_d;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign lane[g] = lane_data_i[g*WIDTH +: WIDTH];
      assign fault_count_o[g*CNT_W +: CNT_W] = fault_cnt_q[g];
   end

   assign active = ~failed_q;

   always_comb begin
      n_active = '0;
      for (int i = 0; i < LANES; i++) begin
         n_active = n_active + AW'(active[i]);
      end
   end

   // agree[i] counts active lanes matching lane i, including lane i itself
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         agree[i] = '0;
         for (int j = 0; j < LANES; j++) begin
            if (active[j] && (lane[j] == lane[i])) begin
               agree[i] = agree[i] + ONE;
            end
         end
      end
   end

   // Lowest-index active lane holding a strict majority supplies the vote
   always_comb begin
      has_maj = 1'b0;
      maj_val = '0;
      for (int i = 0; i < LANES; i++) begin
         if (!has_maj && active[i] && ({agree[i], 1'b0} > {1'b0, n_active})) begin
            has_maj = 1'b1;
            maj_val = lane[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         blame[i] = has_maj && active[i] && (lane[i] != maj_val);
      end
   end

   always_comb begin
      voted_valid_d = valid_i;
      voted_d       = (valid_i && has_maj) ? maj_val : voted_q;
      sys_fault_d   = valid_i && !has_maj;
      lane_fault_d  = (valid_i && !clear_i) ? blame : '0;
   end

   always_comb begin
      failed_d  = failed_q;
      sys_cnt_d = sys_cnt_q;
      for (int i = 0; i < LANES; i++) begin
         streak_d[i]    = streak_q[i];
         fault_cnt_d[i] = fault_cnt_q[i];
      end
      if (clear_i) begin
         failed_d  = '0;
         sys_cnt_d = '0;
         for (int i = 0; i < LANES; i++) begin
            streak_d[i]    = '0;
            fault_cnt_d[i] = '0;
         end
      end else if (valid_i) begin
         if (has_maj) begin
            for (int i = 0; i < LANES; i++) begin
               if (blame[i]) begin
                  streak_d[i] = (streak_q[i] == 8'hFF) ? 8'hFF : streak_q[i] + 8'd1;
                  if (fault_cnt_q[i] != '1) begin
                     fault_cnt_d[i] = fault_cnt_q[i] + CNT_W'(1);
                  end
                  if (streak_d[i] >= THRESH) begin
                     failed_d[i] = 1'b1;
                  end
               end else if (active[i]) begin
                  streak_d[i] = '0;
               end
            end
         end else if (sys_cnt_q != '1) begin
            sys_cnt_d = sys_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         failed_q      <= '0;
         sys_cnt_q     <= '0;
         voted_q       <= '0;
         voted_valid_q <= 1'b0;
         lane_fault_q  <= '0;
         sys_fault_q   <= 1'b0;
         for (int i = 0; i < LANES; i++) begin
            streak_q[i]    <= '0;
            fault_cnt_q[i] <= '0;
         end
      end else begin
         failed_q      <= failed_d;
         sys_cnt_q     <= sys_cnt_d;
         voted_q       <= voted_d;
         voted_valid_q <= voted_valid_d;
         lane_fault_q  <= lane_fault_d;
         sys_fault_q   <= sys_fault_d;
         for (int i = 0; i < LANES; i++) begin
            streak_q[i]    <= streak_d[i];
            fault_cnt_q[i] <= fault_cnt_d[i];
         end
      end
   end

   assign voted_o           = voted_q;
   assign voted_valid_o     = voted_valid_q;
   assign lane_fault_o      = lane_fault_q;
   assign lane_failed_o     = failed_q;
   assign system_fault_o    = sys_fault_q;
   assign sys_fault_count_o = sys_cnt_q;
   assign degraded_o        = |failed_q;

endmodule
